// File: rtl/result_lcd_pkg.sv
// -----------------------------------------------------------------------------
// result_lcd_pkg
//   Shared definitions for the result-to-LCD1602 pager:
//     state_t          FSM state encoding (IDLE/CAPTURE/STREAM/WAIT_KEY)
//     ASCII_SPACE      pad character for cells past the end of the result
//     ASCII_DOT        substitute for non-printable raw bytes
//     nibble_to_ascii  4-bit value -> uppercase hex ASCII digit
// -----------------------------------------------------------------------------
package result_lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_STREAM   = 2'd2,
        ST_WAIT_KEY = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/result_lcd_pager_char_fmt.sv
// -----------------------------------------------------------------------------
// rlp_char_fmt (combinational)
//   Maps a captured result (shadow) plus an LCD cell position on a page to the
//   ASCII code shown in that cell.
//   Optional build macro: HEX_ASCII_EN
//     defined   : every byte shows as two uppercase hex chars, high nibble first
//     undefined : bytes shown raw, non-printables (<0x20, >0x7E) become '.'
//   Cells past the last result character are padded with spaces.
// Ports
//   shadow_i  in  NUM_BYTES*8  captured result, byte k = shadow_i[8k+7:8k]
//   page_i    in  PAGE_W       page being streamed
//   row_i     in  1            LCD row of the cell
//   col_i     in  4            LCD column of the cell
//   char_o    out 8            ASCII code for the cell
// -----------------------------------------------------------------------------
module rlp_char_fmt
    import result_lcd_pkg::*;
#(
    parameter int NUM_BYTES = 50,
    parameter int LCD_COLS  = 16,
    parameter int LCD_ROWS  = 2,
    parameter int PAGE_W    = 3
) (
    input  logic [NUM_BYTES*8-1:0] shadow_i,
    input  logic [PAGE_W-1:0]      page_i,
    input  logic                   row_i,
    input  logic [3:0]             col_i,
    output logic [7:0]             char_o
);

    localparam int PAGE_CHARS = LCD_COLS * LCD_ROWS;
`ifdef HEX_ASCII_EN
    localparam int TOTAL_CHARS = 2 * NUM_BYTES;
`else
    localparam int TOTAL_CHARS = NUM_BYTES;
`endif

    logic [15:0] char_idx;
    logic [15:0] byte_idx;
    logic [7:0]  byte_v;

    always_comb begin
        char_idx = 16'(page_i) * 16'(PAGE_CHARS) + 16'(row_i) * 16'(LCD_COLS) + 16'(col_i);
`ifdef HEX_ASCII_EN
        byte_idx = char_idx >> 1;
`else
        byte_idx = char_idx;
`endif
        // Explicit mux keeps the byte select in range even for pad cells.
        byte_v = ASCII_SPACE;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (byte_idx == 16'(k)) begin
                byte_v = shadow_i[k*8 +: 8];
            end
        end

        char_o = ASCII_SPACE;
        if (char_idx < 16'(TOTAL_CHARS)) begin
`ifdef HEX_ASCII_EN
            char_o = nibble_to_ascii(char_idx[0] ? byte_v[3:0] : byte_v[7:4]);
`else
            if ((byte_v < 8'h20) || (byte_v > 8'h7E)) begin
                char_o = ASCII_DOT;
            end else begin
                char_o = byte_v;
            end
`endif
        end
    end

endmodule

// File: rtl/result_lcd_pager.sv
// -----------------------------------------------------------------------------
// result_lcd_pager
//   Captures the recognition result on each rising edge of done and streams it
//   to an LCD1602 driver as row/col/char writes over valid/ready, one page
//   (LCD_COLS*LCD_ROWS chars) at a time; next_page steps to the following page
//   (wrapping to page 0 after the last one).
//   Optional build macro: HEX_ASCII_EN (hex rendering, see rlp_char_fmt).
// Ports
//   sys_clk     in   1            system clock
//   sys_rst_n   in   1            asynchronous reset, active low
//   done        in   1            result-ready level; rising edge = new result
//   result      in   NUM_BYTES*8  result bus, sampled in the CAPTURE cycle
//   next_page   in   1            one-cycle pulse, honoured only while waiting
//   char_valid  out  1            character write request
//   char_ready  in   1            driver accepts when char_valid & char_ready
//   char_data   out  8            ASCII code
//   char_row    out  1            LCD row
//   char_col    out  4            LCD column
//   page_idx    out  3            page currently shown/streaming
//   busy        out  1            high while a page is streaming
// -----------------------------------------------------------------------------
module result_lcd_pager
    import result_lcd_pkg::*;
#(
    parameter int NUM_BYTES = 50,
    parameter int LCD_COLS  = 16,
    parameter int LCD_ROWS  = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   done,
    input  logic [NUM_BYTES*8-1:0] result,
    input  logic                   next_page,
    output logic                   char_valid,
    input  logic                   char_ready,
    output logic [7:0]             char_data,
    output logic                   char_row,
    output logic [3:0]             char_col,
    output logic [2:0]             page_idx,
    output logic                   busy
);

    localparam int PAGE_CHARS = LCD_COLS * LCD_ROWS;
`ifdef HEX_ASCII_EN
    localparam int TOTAL_CHARS = 2 * NUM_BYTES;
`else
    localparam int TOTAL_CHARS = NUM_BYTES;
`endif
    localparam int NUM_PAGES = (TOTAL_CHARS + PAGE_CHARS - 1) / PAGE_CHARS;
    localparam logic [3:0] LAST_COL = 4'(LCD_COLS - 1);
    localparam logic       LAST_ROW = 1'(LCD_ROWS - 1);

    state_t                 state_q;
    logic                   done_q;
    logic                   pend_q;
    logic [NUM_BYTES*8-1:0] shadow_q;
    logic [2:0]             page_q;
    logic                   row_q;
    logic [3:0]             col_q;
    logic                   valid_q;
    logic                   busy_q;

    logic       done_rise_d;
    logic       last_char_d;
    logic [2:0] page_d;
    logic [7:0] fmt_char;

    assign done_rise_d = done & ~done_q;
    assign last_char_d = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign page_d      = (page_q == 3'(NUM_PAGES - 1)) ? 3'd0 : page_q + 3'd1;

    rlp_char_fmt #(
        .NUM_BYTES (NUM_BYTES),
        .LCD_COLS  (LCD_COLS),
        .LCD_ROWS  (LCD_ROWS),
        .PAGE_W    (3)
    ) u_fmt (
        .shadow_i (shadow_q),
        .page_i   (page_q),
        .row_i    (row_q),
        .col_i    (col_q),
        .char_o   (fmt_char)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            shadow_q <= {NUM_BYTES{ASCII_SPACE}};
            page_q   <= 3'd0;
            row_q    <= 1'b0;
            col_q    <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= done;
            case (state_q)
                ST_IDLE: begin
                    if (done_rise_d) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    shadow_q <= result;
                    page_q   <= 3'd0;
                    row_q    <= 1'b0;
                    col_q    <= 4'd0;
                    pend_q   <= 1'b0;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b1;
                    state_q  <= ST_STREAM;
                end
                ST_STREAM: begin
                    // A new result never interrupts a page; it is remembered
                    // and taken once the current page is complete.
                    if (done_rise_d) pend_q <= 1'b1;
                    if (valid_q && char_ready) begin
                        if (last_char_d) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            row_q   <= 1'b0;
                            col_q   <= 4'd0;
                            state_q <= (pend_q || done_rise_d) ? ST_CAPTURE : ST_WAIT_KEY;
                        end else if (col_q == LAST_COL) begin
                            col_q <= 4'd0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end
                end
                ST_WAIT_KEY: begin
                    if (done_rise_d) begin
                        state_q <= ST_CAPTURE;
                    end else if (next_page) begin
                        page_q  <= page_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_STREAM;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Data bus idles at space whenever no write is being offered.
    assign char_valid = valid_q;
    assign char_data  = valid_q ? fmt_char : ASCII_SPACE;
    assign char_row   = row_q;
    assign char_col   = col_q;
    assign page_idx   = page_q;
    assign busy       = busy_q;

endmodule
